// File: rtl/lsu_data_port_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// error causes and the request legality check.
package lsu_data_port_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_CONFLICT,
    ERR_FUNCT3,
    ERR_MISALIGN,
    ERR_TIMEOUT
  } err_cause_e;

  // Classifies a request at issue time; anything but ERR_NONE completes
  // without touching memory.
  function automatic err_cause_e check_request(input logic       load,
                                               input logic       store,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic legal;
    if (load && store) return ERR_CONFLICT;
    if (store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    if (!legal) return ERR_FUNCT3;
    if ((f3[1:0] == 2'b01) && off[0])         return ERR_MISALIGN;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_data_port_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero
// extension, and store lane replication with byte strobes.
module lsu_align
  import lsu_data_port_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_val
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    byte_v = rdata[{byte_off, 3'b000} +: 8];
    half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
    sext   = ~funct3[2];

    case (funct3[1:0])
      2'b00:   load_val = {{24{sext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{sext & half_v[15]}}, half_v};
      default: load_val = rdata;
    endcase

    // Loads present an all-zero write beat.
    wdata = '0;
    wstrb = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << byte_off;
        end
        2'b01: begin
          wdata = {2{store_data[15:0]}};
          wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit: turns execute-stage load/store ops into req/ready/rvalid
// memory transactions and stalls the core until each one completes.
module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  // Counter only needs to reach TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_reg;
  err_cause_e        cause_reg;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-3:0] word_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       load_data_reg;

  logic        in_idle;
  logic [2:0]  align_f3;
  logic [1:0]  align_off;
  logic        align_store;
  logic [31:0] align_wdata;
  logic [3:0]  align_wstrb;
  logic [31:0] align_load;
  err_cause_e  req_cause;
  logic        timed_out;

  // In IDLE the aligner sees the live request so the write beat can be
  // captured; afterwards it sees the latched op for load extraction.
  assign in_idle     = (state_reg == IDLE);
  assign align_f3    = in_idle ? funct3 : funct3_reg;
  assign align_off   = in_idle ? addr[1:0] : off_reg;
  assign align_store = in_idle ? (store & ~load) : we_reg;
  assign req_cause   = check_request(load, store, funct3, addr[1:0]);
  assign timed_out   = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .funct3     (align_f3),
    .byte_off   (align_off),
    .is_store   (align_store),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_val   (align_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cause_reg     <= ERR_NONE;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      off_reg       <= '0;
      word_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      cnt_reg       <= '0;
      load_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (load || store) begin
            we_reg     <= store & ~load;
            funct3_reg <= funct3;
            off_reg    <= addr[1:0];
            word_reg   <= addr[ADDR_W-1:2];
            wdata_reg  <= align_wdata;
            wstrb_reg  <= align_wstrb;
            cause_reg  <= req_cause;
            if (req_cause != ERR_NONE) begin
              load_data_reg <= '0;
              state_reg     <= DONE;
            end else begin
              state_reg <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_ready) begin
            cnt_reg   <= '0;
            state_reg <= we_reg ? DONE : WAIT_R;
          end else if (timed_out) begin
            cause_reg     <= ERR_TIMEOUT;
            load_data_reg <= '0;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            load_data_reg <= align_load;
            state_reg     <= DONE;
          end else if (timed_out) begin
            cause_reg     <= ERR_TIMEOUT;
            load_data_reg <= '0;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          cause_reg <= ERR_NONE;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign stall      = (load | store) & (state_reg != DONE);
  assign done       = (state_reg == DONE);
  assign err        = done && (cause_reg != ERR_NONE);
  assign load_data  = load_data_reg;
  assign dmem_req   = (state_reg == REQ);
  assign dmem_we    = we_reg;
  assign dmem_addr  = {word_reg, 2'b00};
  assign dmem_wdata = wdata_reg;
  assign dmem_wstrb = wstrb_reg;

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port: loads, stores, error completions,
// timeout abort and reset during an outstanding read.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_data_port #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .store       (store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .stall       (stall),
    .done        (done),
    .load_data   (load_data),
    .err         (err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input int ready_delay,
                         input logic [31:0] exp_data);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    load = 1'b1; funct3 = f3; addr = a;
    #1;
    chk({tag, " c1 stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " c1 req"}, {31'd0, dmem_req}, 32'd0);
    tick();
    for (int i = 0; i < ready_delay; i++) begin
      chk({tag, " wait req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, " wait addr"}, dmem_addr, wa);
      addr = 32'hFFFF_FFF0;
      tick();
    end
    dmem_ready = 1'b1;
    chk({tag, " req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, " addr"}, dmem_addr, wa);
    chk({tag, " we/strb"}, {27'd0, dmem_we, dmem_wstrb}, 32'd0);
    chk({tag, " wdata"}, dmem_wdata, 32'd0);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
    chk({tag, " waitr req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, " waitr stall"}, {31'd0, stall}, 32'd1);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    chk({tag, " done/err/stall"}, {29'd0, done, err, stall}, 32'b100);
    chk({tag, " load_data"}, load_data, exp_data);
    load = 1'b0;
    tick();
    chk({tag, " idle done"}, {31'd0, done}, 32'd0);
    chk({tag, " held load_data"}, load_data, exp_data);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int ready_delay,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
    store = 1'b1; funct3 = f3; addr = a; store_data = sd;
    #1;
    chk({tag, " c1 stall"}, {31'd0, stall}, 32'd1);
    tick();
    for (int i = 0; i < ready_delay; i++) begin
      chk({tag, " wait req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, " wait wdata"}, dmem_wdata, exp_wdata);
      chk({tag, " wait addr"}, dmem_addr, exp_addr);
      store_data = ~sd; addr = a ^ 32'h0000_0F04;
      tick();
    end
    dmem_ready = 1'b1;
    chk({tag, " req/we"}, {30'd0, dmem_req, dmem_we}, 32'b11);
    chk({tag, " addr"}, dmem_addr, exp_addr);
    chk({tag, " wdata"}, dmem_wdata, exp_wdata);
    chk({tag, " wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_wstrb});
    tick();
    dmem_ready = 1'b0;
    chk({tag, " done/err/stall"}, {29'd0, done, err, stall}, 32'b100);
    store = 1'b0;
    tick();
    chk({tag, " idle done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_error(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a);
    load = ld; store = st; funct3 = f3; addr = a;
    #1;
    chk({tag, " c1 stall/req"}, {30'd0, stall, dmem_req}, 32'b10);
    tick();
    chk({tag, " done/err/req"}, {29'd0, done, err, dmem_req}, 32'b110);
    chk({tag, " load_data"}, load_data, 32'd0);
    load = 1'b0; store = 1'b0;
    tick();
    chk({tag, " idle"}, {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("reset outs", {27'd0, stall, done, err, dmem_req, dmem_we}, 32'd0);
    chk("reset load_data", load_data, 32'd0);
    chk("reset strb/wdata", dmem_wdata | {28'd0, dmem_wstrb}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_load("LW 100", 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    do_load("LB 103", 3'b000, 32'h103, 32'h80123456, 0, 32'hFFFFFF80);
    do_load("LBU 103", 3'b100, 32'h103, 32'h80123456, 0, 32'h00000080);
    do_load("LH 102", 3'b001, 32'h102, 32'h80123456, 0, 32'hFFFF8012);
    do_load("LHU 100", 3'b101, 32'h100, 32'h8012B456, 0, 32'h0000B456);
    do_load("LB 101", 3'b000, 32'h101, 32'h80123456, 0, 32'h00000034);

    do_store("SH 22", 3'b001, 32'h22, 32'h1234ABCD, 0, 32'h20, 32'hABCDABCD, 4'b1100);
    chk("store keeps load_data", load_data, 32'h00000034);
    do_store("SB 41", 3'b000, 32'h41, 32'h000000A5, 0, 32'h40, 32'hA5A5A5A5, 4'b0010);
    do_store("SW 80", 3'b010, 32'h80, 32'h01234567, 0, 32'h80, 32'h01234567, 4'b1111);

    do_error("LW misaligned", 1'b1, 1'b0, 3'b010, 32'h102);
    do_error("LD f3 011", 1'b1, 1'b0, 3'b011, 32'h100);
    do_error("SB f3 100", 1'b0, 1'b1, 3'b100, 32'h100);
    do_error("LD+ST", 1'b1, 1'b1, 3'b010, 32'h100);
    do_error("SH odd", 1'b0, 1'b1, 3'b001, 32'h101);

    // Timeout in REQ: four request cycles, then an error completion.
    load = 1'b1; funct3 = 3'b010; addr = 32'h200;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("TO req high", {30'd0, dmem_req, done}, 32'b10);
      tick();
    end
    chk("TO done/err/req", {29'd0, done, err, dmem_req}, 32'b110);
    chk("TO load_data", load_data, 32'd0);
    load = 1'b0;
    tick();

    do_load("LW ready+2", 3'b010, 32'h204, 32'h13579BDF, 2, 32'h13579BDF);
    do_store("SW ready+2", 3'b010, 32'h208, 32'h2468ACE0, 2, 32'h208, 32'h2468ACE0, 4'b1111);

    // Reset while a read is outstanding, then a stray rvalid.
    load = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("RST pre waitr", {30'd0, stall, dmem_req}, 32'b10);
    rst_n = 1'b0; load = 1'b0;
    #1;
    chk("RST outs", {28'd0, stall, dmem_req, done, err}, 32'd0);
    chk("RST load_data", load_data, 32'd0);
    tick();
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
    tick();
    dmem_rvalid = 1'b0;
    chk("RST late rvalid", {29'd0, stall, dmem_req, done}, 32'd0);
    chk("RST late load_data", load_data, 32'd0);
    tick();
    chk("RST still idle", {29'd0, dmem_req, done, err}, 32'd0);
    do_load("LW after rst", 3'b010, 32'h304, 32'hCAFEF00D, 0, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
Load/store unit between the execute stage and the data memory. It is the producer of the load data that the writeback stage selects for the register file. It converts a load/store request into a req/ready/rvalid memory transaction and stalls the core while the access is pending. For loads it returns byte/half/word data, aligned and sign- or zero-extended. For stores it drives lane-replicated write data with byte strobes.

Parameters:
TIMEOUT, 255, max cycles waiting in REQ or WAIT_R before aborting; 0 disables the timeout.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
load  in  1  load instruction in execute.
store  in  1  store instruction in execute.
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  in  ADDR_W  effective byte address (ALU result).
store_data  in  32  rs2 value.
stall  out  1  core must hold PC and inputs.
done  out  1  one-cycle completion pulse.
load_data  out  32  extended load result, to writeback.
err  out  1  one-cycle pulse with done on misaligned, illegal funct3, load&store, or timeout.
dmem_req  out  1  memory request.
dmem_we  out  1  1 = write.
dmem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 00).
dmem_wdata  out  32  write data.
dmem_wstrb  out  4  byte enables.
dmem_ready  in  1  request accepted this cycle.
dmem_rvalid  in  1  read data valid.
dmem_rdata  in  32  read word.

Behaviour:
- Reset (async): state IDLE, all outputs 0, timeout counter 0. dmem_req drops immediately. A transaction in flight is abandoned; a late dmem_rvalid after reset is ignored in IDLE.
- stall = (load|store) & (state != DONE). It is combinational, so the core stalls in the same cycle the op appears.
- IDLE: when load|store is seen, latch op, funct3, addr[1:0], word address, wdata and wstrb. Changes to inputs after this are ignored.
  - Error checks: illegal funct3 (load: 011/11x; store: anything other than 000/001/010), load&store both set, H with addr[0]=1, or W with addr[1:0]!=00. On any of these → DONE with error flag set and no memory request.
  - Otherwise → REQ.
- REQ: dmem_req=1, with dmem_we/addr/wdata/wstrb held stable until dmem_ready=1.
  - On ready: store → DONE; load → WAIT_R.
  - dmem_rvalid is ignored in REQ.
- WAIT_R: on dmem_rvalid, register the extracted data → DONE.
- Timeout: the counter clears on entering REQ and on REQ→WAIT_R. When it reaches TIMEOUT in either state → DONE with error; req drops.
- DONE: done=1 and stall=0 for exactly one cycle; err=1 if the error flag is set; → IDLE. A new op may be latched in the following IDLE cycle.
- load_data: registered and updated only on a successful load. It holds its value until the next load completes. Error completions drive load_data=0.
  - LB/LBU: byte = rdata[8*a+7:8*a], where a = addr[1:0]. LH/LHU: half = rdata[16*a1+15:16*a1], where a1 = addr[1]. Sign-extend for B/H, zero-extend for BU/HU. LW: the word as-is.
- Store encoding:
  - SB: wdata = byte replicated 4×, wstrb = 0001<<a.
  - SH: wdata = half replicated 2×, wstrb = 0011 (a1=0) or 1100 (a1=1).
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000 and wdata = 0.
- Latency with zero wait states: store 3 cycles (IDLE, REQ, DONE). Load 4 cycles (rvalid earliest the cycle after ready).

Decomposition:
- Shared package: funct3 size encodings, FSM state enum (IDLE, REQ, WAIT_R, DONE), and error-cause constants.
- One natural sub-module, lsu_align: combinational load extraction/extension and store replication/strobe generation. The FSM lives in lsu_data_port.

Test Plan:
- LW addr=0x100, ready in REQ, rvalid next cycle with rdata=0xDEADBEEF → dmem_addr=0x100, stall high for 3 cycles, done in cycle 4, load_data=0xDEADBEEF, err=0.
- LB addr=0x103, rdata=0x80_12_34_56 → load_data=0xFFFFFF80. LBU, same stimulus → 0x00000080.
- SH addr=0x22, store_data=0x1234ABCD → dmem_addr=0x20, dmem_wdata=0xABCDABCD, wstrb=1100, we=1, done 3 cycles after the op appears.
- LW addr=0x102 → no dmem_req, done+err in cycle 2, load_data=0. funct3=011 load → same result.
- TIMEOUT=4, dmem_ready held 0 → req high for 4 cycles, then done+err. Then LW with ready delayed 2 cycles → wdata/addr stable during the wait; completes normally.
- rst_n low during WAIT_R, then rvalid pulses → stall/req/done stay 0, state IDLE. The next LW completes normally.
